// File: rtl/mouse_transmitter_if.sv
// rtl/mouse_transmitter_if.sv - host command handshake between a controller and the PS/2 transmitter
interface mouse_transmitter_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BUSY;
  logic       BYTE_SENT;
  logic [1:0] ERROR_CODE;

  modport master (
    output SEND_BYTE,
    output BYTE_TO_SEND,
    input  BUSY,
    input  BYTE_SENT,
    input  ERROR_CODE
  );

  modport slave (
    input  SEND_BYTE,
    input  BYTE_TO_SEND,
    output BUSY,
    output BYTE_SENT,
    output ERROR_CODE
  );
endinterface

// File: rtl/mouse_transmitter.sv
// rtl/mouse_transmitter.sv - PS/2 host-to-device byte transmitter with inhibit, start, send, ack and timeout handling
module mouse_transmitter #(
  parameter int INHIBIT_CYCLES     = 12000,
  parameter int START_SETUP_CYCLES = 20,
  parameter int TIMEOUT_CYCLES     = 50000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CLK_MOUSE_IN,
  input  logic                DATA_MOUSE_IN,
  output logic                CLK_MOUSE_OUT_EN,
  output logic                DATA_MOUSE_OUT_EN,
  mouse_transmitter_if.slave  host
);

  localparam int MAX_A      = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > START_SETUP_CYCLES) ? MAX_A : START_SETUP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    START   = 3'd2,
    SEND    = 3'd3,
    ACK     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    edge_q, edge_d;
  logic [7:0]    byte_q, byte_d;
  logic          parity_q, parity_d;
  logic [1:0]    err_q, err_d;
  logic          clk_en_q, clk_en_d;
  logic          data_en_q, data_en_d;
  logic          byte_sent_q, byte_sent_d;
  logic          busy_q, busy_d;
  logic          clk_reg_q, clk_reg_d;
  logic          falling;

  assign falling = clk_reg_q & ~CLK_MOUSE_IN;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    edge_d      = edge_q;
    byte_d      = byte_q;
    parity_d    = parity_q;
    err_d       = err_q;
    clk_en_d    = clk_en_q;
    data_en_d   = data_en_q;
    byte_sent_d = 1'b0;
    clk_reg_d   = CLK_MOUSE_IN;

    case (state_q)
      IDLE: begin
        clk_en_d  = 1'b0;
        data_en_d = 1'b0;
        if (host.SEND_BYTE) begin
          byte_d   = host.BYTE_TO_SEND;
          parity_d = ~^host.BYTE_TO_SEND;
          err_d    = 2'b00;
          count_d  = '0;
          edge_d   = 4'd0;
          clk_en_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (count_q == CW'(INHIBIT_CYCLES - 1)) begin
          count_d   = '0;
          data_en_d = 1'b1;
          state_d   = START;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      START: begin
        if (count_q == CW'(START_SETUP_CYCLES - 1)) begin
          count_d  = '0;
          clk_en_d = 1'b0;
          state_d  = SEND;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      SEND: begin
        // Device clock falling edges shift the next bit onto the line: data LSB first, parity, then stop.
        if (falling) begin
          count_d = '0;
          edge_d  = edge_q + 4'd1;
          if (edge_q <= 4'd7) begin
            data_en_d = ~byte_q[edge_q[2:0]];
          end else if (edge_q == 4'd8) begin
            data_en_d = ~parity_q;
          end else begin
            data_en_d = 1'b0;
            state_d   = ACK;
          end
        end else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d[0]    = 1'b1;
          clk_en_d    = 1'b0;
          data_en_d   = 1'b0;
          count_d     = '0;
          byte_sent_d = 1'b1;
          state_d     = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      ACK: begin
        if (falling) begin
          err_d[1]    = err_q[1] | DATA_MOUSE_IN;
          count_d     = '0;
          byte_sent_d = 1'b1;
          state_d     = DONE;
        end else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d[0]    = 1'b1;
          clk_en_d    = 1'b0;
          data_en_d   = 1'b0;
          count_d     = '0;
          byte_sent_d = 1'b1;
          state_d     = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        clk_en_d  = 1'b0;
        data_en_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d   = IDLE;
        count_d   = '0;
        edge_d    = 4'd0;
        byte_d    = 8'd0;
        parity_d  = 1'b0;
        err_d     = 2'b00;
        clk_en_d  = 1'b0;
        data_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      count_q     <= '0;
      edge_q      <= 4'd0;
      byte_q      <= 8'd0;
      parity_q    <= 1'b0;
      err_q       <= 2'b00;
      clk_en_q    <= 1'b0;
      data_en_q   <= 1'b0;
      byte_sent_q <= 1'b0;
      busy_q      <= 1'b0;
      clk_reg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      edge_q      <= edge_d;
      byte_q      <= byte_d;
      parity_q    <= parity_d;
      err_q       <= err_d;
      clk_en_q    <= clk_en_d;
      data_en_q   <= data_en_d;
      byte_sent_q <= byte_sent_d;
      busy_q      <= busy_d;
      clk_reg_q   <= clk_reg_d;
    end
  end

  assign CLK_MOUSE_OUT_EN  = clk_en_q;
  assign DATA_MOUSE_OUT_EN = data_en_q;
  assign host.BUSY         = busy_q;
  assign host.BYTE_SENT    = byte_sent_q;
  assign host.ERROR_CODE   = err_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// tb/tb_mouse_transmitter.sv - directed bench with an open-drain PS/2 device model
module tb_mouse_transmitter;
  localparam int INH = 20;
  localparam int SS  = 4;
  localparam int TO  = 200;

  logic clk;
  logic resetn;
  logic dev_clk;
  logic dev_data;
  logic clk_en;
  logic data_en;
  logic clk_line;
  logic data_line;

  mouse_transmitter_if host_if ();

  mouse_transmitter #(
    .INHIBIT_CYCLES     (INH),
    .START_SETUP_CYCLES (SS),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .CLK               (clk),
    .RESET             (resetn),
    .CLK_MOUSE_IN      (clk_line),
    .DATA_MOUSE_IN     (data_line),
    .CLK_MOUSE_OUT_EN  (clk_en),
    .DATA_MOUSE_OUT_EN (data_en),
    .host              (host_if.slave)
  );

  assign clk_line  = dev_clk & ~clk_en;
  assign data_line = dev_data & ~data_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passes;
  int cyc;
  int sent_cnt;
  int inh_cnt;
  int setup_cnt;
  int viol_cnt;
  int sent_cyc;
  logic [1:0] last_err;
  logic       last_en;

  initial begin
    cyc = 0; sent_cnt = 0; inh_cnt = 0; setup_cnt = 0; viol_cnt = 0;
    sent_cyc = 0; last_err = 2'b00; last_en = 1'b0;
  end

  always @(negedge clk) begin
    cyc++;
    if (host_if.BYTE_SENT === 1'b1) begin
      sent_cnt++;
      sent_cyc = cyc;
      last_err = host_if.ERROR_CODE;
      last_en  = clk_en | data_en;
    end
    if (clk_en && !data_en) inh_cnt++;
    if (clk_en && data_en) setup_cnt++;
    if (!host_if.BUSY && (clk_en || data_en)) viol_cnt++;
  end

  task automatic do_send(input logic [7:0] b);
    @(negedge clk);
    host_if.SEND_BYTE    = 1'b1;
    host_if.BYTE_TO_SEND = b;
    @(negedge clk);
    host_if.SEND_BYTE    = 1'b0;
  endtask

  task automatic device_clock(input int n, input logic ack_low, output logic [10:0] b, output int last_fall);
    int t;
    b = '0;
    last_fall = 0;
    t = 0;
    while (!(host_if.BUSY && !clk_en && data_en) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      $display("FAIL device_start: host never released clock with start bit (waited %0d cycles)", t);
    end else begin
      for (int e = 1; e <= n; e++) begin
        repeat (6) @(negedge clk);
        b[e-1] = data_line;
        if (e == 11 && ack_low) begin
          dev_data = 1'b0;
          @(negedge clk);
        end
        dev_clk = 1'b0;
        last_fall = cyc;
        repeat (6) @(negedge clk);
        dev_clk = 1'b1;
      end
      repeat (2) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (clk_en !== 1'b0) $display("FAIL reset_clk_en: got %b want 0", clk_en); else passes++;
    checks++; if (data_en !== 1'b0) $display("FAIL reset_data_en: got %b want 0", data_en); else passes++;
    checks++; if (host_if.BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", host_if.BUSY); else passes++;
    checks++; if (host_if.BYTE_SENT !== 1'b0) $display("FAIL reset_byte_sent: got %b want 0", host_if.BYTE_SENT); else passes++;
    checks++; if (host_if.ERROR_CODE !== 2'b00) $display("FAIL reset_error: got %b want 00", host_if.ERROR_CODE); else passes++;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full(input string name, input logic [7:0] b, input logic ack_low,
                           input logic [10:0] exp_bits, input logic [1:0] exp_err);
    logic [10:0] got;
    int lf;
    int s0;
    s0 = sent_cnt;
    do_send(b);
    device_clock(11, ack_low, got, lf);
    repeat (4) @(negedge clk);
    checks++; if (got !== exp_bits) $display("FAIL %s_bits: got %h want %h", name, got, exp_bits); else passes++;
    checks++; if (sent_cnt - s0 != 1) $display("FAIL %s_sent_pulses: got %0d want 1", name, sent_cnt - s0); else passes++;
    checks++; if (last_err !== exp_err) $display("FAIL %s_error: got %b want %b", name, last_err, exp_err); else passes++;
    checks++; if (host_if.BUSY !== 1'b0) $display("FAIL %s_busy_after: got %b want 0", name, host_if.BUSY); else passes++;
    checks++; if (host_if.ERROR_CODE !== exp_err) $display("FAIL %s_error_held: got %b want %b", name, host_if.ERROR_CODE, exp_err); else passes++;
  endtask

  task automatic test_timeout;
    logic [10:0] got;
    int lf;
    int s0;
    int t;
    s0 = sent_cnt;
    do_send(8'h00);
    device_clock(4, 1'b0, got, lf);
    t = 0;
    while (sent_cnt == s0 && t < TO + 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sent_cnt == s0) $display("FAIL timeout_wait: no BYTE_SENT within %0d cycles", TO + 100);
    else passes++;
    checks++; if (got[3:0] !== 4'b0000) $display("FAIL timeout_bits: got %b want 0000", got[3:0]); else passes++;
    checks++;
    if (sent_cyc - lf < TO - 3 || sent_cyc - lf > TO + 3)
      $display("FAIL timeout_latency: got %0d want %0d+-3", sent_cyc - lf, TO);
    else passes++;
    checks++; if (last_err !== 2'b01) $display("FAIL timeout_error: got %b want 01", last_err); else passes++;
    checks++; if (last_en !== 1'b0) $display("FAIL timeout_release: got %b want 0", last_en); else passes++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_repulse;
    logic [10:0] got;
    int lf;
    int s0;
    int i0;
    int u0;
    int busy_seen;
    s0 = sent_cnt; i0 = inh_cnt; u0 = setup_cnt;
    @(negedge clk);
    host_if.SEND_BYTE = 1'b1;
    host_if.BYTE_TO_SEND = 8'hA5;
    repeat (3) @(negedge clk);
    host_if.SEND_BYTE = 1'b0;
    host_if.BYTE_TO_SEND = 8'h12;
    repeat (4) @(negedge clk);
    host_if.SEND_BYTE = 1'b1;
    @(negedge clk);
    host_if.SEND_BYTE = 1'b0;
    device_clock(11, 1'b1, got, lf);
    repeat (4) @(negedge clk);
    checks++; if (inh_cnt - i0 != INH) $display("FAIL hold_inhibit_len: got %0d want %0d", inh_cnt - i0, INH); else passes++;
    checks++; if (setup_cnt - u0 != SS) $display("FAIL hold_setup_len: got %0d want %0d", setup_cnt - u0, SS); else passes++;
    checks++; if (got !== 11'h74A) $display("FAIL hold_bits: got %h want 74a", got); else passes++;
    busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (host_if.BUSY) busy_seen++;
    end
    checks++; if (busy_seen != 0) $display("FAIL hold_no_second: busy for %0d cycles want 0", busy_seen); else passes++;
    checks++; if (sent_cnt - s0 != 1) $display("FAIL hold_sent_pulses: got %0d want 1", sent_cnt - s0); else passes++;
  endtask

  task automatic test_reset_mid;
    logic [10:0] got;
    int lf;
    int s0;
    s0 = sent_cnt;
    do_send(8'h3C);
    device_clock(5, 1'b0, got, lf);
    checks++; if (host_if.BUSY !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", host_if.BUSY); else passes++;
    resetn = 1'b0;
    @(negedge clk);
    checks++; if ({clk_en, data_en} !== 2'b00) $display("FAIL midrst_enables: got %b want 00", {clk_en, data_en}); else passes++;
    checks++; if (host_if.BUSY !== 1'b0) $display("FAIL midrst_busy: got %b want 0", host_if.BUSY); else passes++;
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (sent_cnt != s0) $display("FAIL midrst_no_sent: got %0d pulses want 0", sent_cnt - s0); else passes++;
    test_full("after_reset_e6", 8'hE6, 1'b1, 11'h5CC, 2'b00);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    resetn = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    host_if.SEND_BYTE = 1'b0;
    host_if.BYTE_TO_SEND = 8'h00;
    test_reset();
    test_full("f4", 8'hF4, 1'b1, 11'h5E8, 2'b00);
    test_full("ff_noack", 8'hFF, 1'b0, 11'h7FE, 2'b10);
    test_timeout();
    test_hold_repulse();
    test_reset_mid();
    checks++; if (viol_cnt != 0) $display("FAIL idle_drive: lines driven while idle for %0d cycles", viol_cnt); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mouse_transmitter.md
MOUSE_TRANSMITTER -- requirements
Module: mouse_transmitter

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 12000, clock-low inhibit length in CLK cycles (120 us at 100 MHz).
REQ-002 SHALL have parameter START_SETUP_CYCLES, default 20, cycles with both lines held low before the clock is released.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, maximum wait between device clock falling edges.
REQ-004 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-low reset.
REQ-006 SHALL have port CLK_MOUSE_IN  input  1  PS/2 clock line, sampled.
REQ-007 SHALL have port DATA_MOUSE_IN  input  1  PS/2 data line, sampled.
REQ-008 SHALL have port CLK_MOUSE_OUT_EN  output  1  1 = drive PS/2 clock low; 0 = release.
REQ-009 SHALL have port DATA_MOUSE_OUT_EN  output  1  1 = drive PS/2 data low; 0 = release (line reads 1).
REQ-010 SHALL have port SEND_BYTE  input  1  request strobe; sampled only in IDLE.
REQ-011 SHALL have port BYTE_TO_SEND  input  8  command byte; latched when the request is accepted.
REQ-012 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-013 SHALL have port BYTE_SENT  output  1  one-cycle completion pulse.
REQ-014 SHALL have port ERROR_CODE  output  2  bit0 = timeout, bit1 = no ACK; valid from the BYTE_SENT cycle until the next accept.

Function
REQ-015 SHALL register CLK_MOUSE_IN once; a falling edge is registered=1 and current=0.
REQ-016 SHALL implement states IDLE, INHIBIT, START, SEND, ACK, DONE.
REQ-017 IDLE: if SEND_BYTE=1, SHALL latch BYTE_TO_SEND, compute odd parity (XNOR-reduce of byte), clear ERROR_CODE and counters, and go to INHIBIT next cycle; falling edges are ignored.
REQ-018 INHIBIT: CLK_MOUSE_OUT_EN=1, DATA_MOUSE_OUT_EN=0 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-019 START: CLK_MOUSE_OUT_EN=1, DATA_MOUSE_OUT_EN=1 (start bit 0) for START_SETUP_CYCLES cycles, then go to SEND with CLK_MOUSE_OUT_EN=0.
REQ-020 SEND: on falling edges 1-8, DATA_MOUSE_OUT_EN SHALL become ~byte[n-1] (LSB first); edge 9 ~parity; edge 10 release (stop bit 1), then go to ACK.
REQ-021 ACK: on the next falling edge, SHALL sample DATA_MOUSE_IN; 1 sets ERROR_CODE[1]; go to DONE.
REQ-022 SEND/ACK: timeout counter SHALL clear on every falling edge and on state entry; reaching TIMEOUT_CYCLES SHALL set ERROR_CODE[0], release both lines, and go to DONE.
REQ-023 DONE: BYTE_SENT=1 for exactly one cycle, both enables 0, then go to IDLE.
REQ-024 SEND_BYTE asserted while BUSY SHALL be ignored (not queued).
REQ-025 SHALL never assert CLK_MOUSE_OUT_EN outside INHIBIT/START; DATA_MOUSE_OUT_EN only in START/SEND.
REQ-026 Counters SHALL be wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) without wrap; edge counter 4 bits.

Reset
REQ-027 RESET=0 at a CLK edge SHALL force IDLE, enables 0, BUSY 0, BYTE_SENT 0, ERROR_CODE 00, all counters and latched byte 0.
REQ-028 Reset mid-transfer SHALL release both lines on the following cycle with no BYTE_SENT pulse.
REQ-029 Unused state encodings SHALL recover to IDLE with reset values.

Verification
REQ-030 Send 0xF4, device model clocks 11 edges and pulls data low on edge 11 -> line bits 0,0,0,1,0,1,1,1,1,0(parity),1(stop); BYTE_SENT pulse; ERROR_CODE=00.
REQ-031 Send 0xFF, ACK edge data=1 -> parity bit 1, BYTE_SENT pulse, ERROR_CODE=10.
REQ-032 Send 0x00, device stops after edge 4 -> after TIMEOUT_CYCLES, both enables 0, BYTE_SENT pulse, ERROR_CODE=01.
REQ-033 SEND_BYTE held for 3 cycles and re-pulsed during INHIBIT -> exactly one transfer, clock held low exactly INHIBIT_CYCLES cycles.
REQ-034 RESET=0 during SEND bit 5 -> next cycle enables 0, BUSY 0, no BYTE_SENT; subsequent send of 0xE6 completes with ERROR_CODE=00.
